aes_block_serializer: RTL

- Output-side datapath between the AES core and the HWPE output sink streamer (aes_output_sink).
- Takes 128-bit result blocks from the core and emits them as 32-bit words on a valid/ready stream, with byte strobes and a last flag.
- Enforces the programmed job byte length (HWPE_DATA_BYTE_LENGTH) and reports completion to the controller FSM.
- Performs the opposite direction of the input gather path, which packs four stream words into one core block.

---
 rtl/aes_block_serializer_if.sv | 45 ++++
 rtl/aes_block_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/aes_block_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_serializer_if
// Description : Block-side and stream-side handshake bundle of the AES
//               output serializer (core result block in, 32-bit words out).
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_block_serializer_if #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32
);
    logic                  block_valid_i;
    logic [BLOCK_W-1:0]    block_data_i;
    logic                  block_ready_o;
    logic [WORD_W-1:0]     data_o;
    logic [WORD_W/8-1:0]   strb_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  last_o;

    // Serializer side
    modport master (
        input  block_valid_i,
        input  block_data_i,
        output block_ready_o,
        output data_o,
        output strb_o,
        output valid_o,
        input  ready_i,
        output last_o
    );

    // Core / sink side
    modport slave (
        output block_valid_i,
        output block_data_i,
        input  block_ready_o,
        input  data_o,
        input  strb_o,
        input  valid_o,
        output ready_i,
        input  last_o
    );
endinterface
`default_nettype wire

// File: rtl/aes_block_serializer.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_serializer
// Description : Splits 128-bit AES result blocks into 32-bit stream words,
//               trims the tail to the programmed job byte length.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_block_serializer #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32,
    parameter int CNT_W   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       data_size_i,
    aes_block_serializer_if.master bus,
    output logic [CNT_W-1:0]       bytes_sent_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int c_WORDS = BLOCK_W / WORD_W;
    localparam int c_BPW   = WORD_W / 8;
    localparam int c_IDX_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;

    localparam logic [CNT_W-1:0]   c_BPW_CNT  = CNT_W'(c_BPW);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_WORDS - 1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WAIT_BLK = 2'd1;
    localparam logic [1:0] c_ST_SEND     = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [BLOCK_W-1:0] r_hold;
    logic [c_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_bytes_sent;

    logic [WORD_W-1:0]  w_words [c_WORDS];
    logic               w_word_hs;
    logic               w_last_word;
    logic               w_blk_end;
    logic [CNT_W-1:0]   w_take;
    logic               w_blk_hs;

    logic               w_blk_ready;
    logic               w_valid;
    logic [WORD_W-1:0]  w_data;
    logic [c_BPW-1:0]   w_strb;
    logic               w_last;
    logic               w_busy;
    logic               w_done;

    // Word 0 is the most significant slice of the block
    for (genvar gi = 0; gi < c_WORDS; gi++) begin : g_words
        assign w_words[gi] = r_hold[BLOCK_W-1-WORD_W*gi -: WORD_W];
    end

    assign w_word_hs   = (r_state == c_ST_SEND) && bus.ready_i;
    assign w_last_word = (r_remaining <= c_BPW_CNT);
    assign w_blk_end   = (r_idx == c_LAST_IDX);
    assign w_take      = w_last_word ? r_remaining : c_BPW_CNT;
    assign w_blk_hs    = bus.block_valid_i && w_blk_ready;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (clear_i) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        w_next_state = (data_size_i == '0) ? c_ST_DONE : c_ST_WAIT_BLK;
                    end
                end
                c_ST_WAIT_BLK: begin
                    if (w_blk_hs) begin
                        w_next_state = c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (w_word_hs) begin
                        if (w_last_word) begin
                            w_next_state = c_ST_DONE;
                        end else if (w_blk_end && !w_blk_hs) begin
                            w_next_state = c_ST_WAIT_BLK;
                        end
                    end
                end
                c_ST_DONE: begin
                    w_next_state = c_ST_IDLE;
                end
                default: begin
                    w_next_state = c_ST_IDLE;
                end
            endcase
        end
    end

    // Output logic; a clear cycle never accepts a block
    always_comb begin
        w_blk_ready = 1'b0;
        w_valid     = 1'b0;
        w_data      = '0;
        w_strb      = '0;
        w_last      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_ST_WAIT_BLK: begin
                w_busy      = 1'b1;
                w_blk_ready = !clear_i;
            end
            c_ST_SEND: begin
                w_busy      = 1'b1;
                w_valid     = 1'b1;
                w_data      = w_words[r_idx];
                w_last      = w_last_word;
                for (int b = 0; b < c_BPW; b++) begin
                    w_strb[b] = (r_remaining > CNT_W'(b));
                end
                w_blk_ready = w_word_hs && w_blk_end && !w_last_word && !clear_i;
            end
            c_ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Datapath: holding register, word index and byte counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold       <= '0;
            r_idx        <= '0;
            r_remaining  <= '0;
            r_bytes_sent <= '0;
        end else if (clear_i) begin
            r_hold       <= '0;
            r_idx        <= '0;
            r_remaining  <= '0;
            r_bytes_sent <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && start_i) begin
                r_remaining  <= data_size_i;
                r_bytes_sent <= '0;
            end
            if (w_word_hs) begin
                r_remaining  <= r_remaining - w_take;
                r_bytes_sent <= r_bytes_sent + w_take;
                r_idx        <= r_idx + c_IDX_W'(1);
            end
            if (w_blk_hs) begin
                r_hold <= bus.block_data_i;
                r_idx  <= '0;
            end
        end
    end

    assign bus.block_ready_o = w_blk_ready;
    assign bus.valid_o       = w_valid;
    assign bus.data_o        = w_data;
    assign bus.strb_o        = w_strb;
    assign bus.last_o        = w_last;
    assign bytes_sent_o      = r_bytes_sent;
    assign busy_o            = w_busy;
    assign done_o            = w_done;

endmodule
`default_nettype wire
